// File: rtl/axi_lite_pkg.sv
// Shared constants and helpers for the AXI4-Lite register bank.
// Response codes, ID register location and byte-merge helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned REG_ID_IDX = 15;

  localparam logic [31:0] ID_VALUE_DEF = 32'hDA7A_0001;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite signal bundle used to hook a master to the register bank.
// Carries the full AW/W/B/AR/R signal set.
interface axi_lite_if #(
  parameter int AW = 32
);
  logic [AW-1:0] AWADDR;
  logic [2:0]    AWPROT;
  logic          AWVALID;
  logic          AWREADY;
  logic [31:0]   WDATA;
  logic [3:0]    WSTRB;
  logic          WVALID;
  logic          WREADY;
  logic          BREADY;
  logic          BVALID;
  logic [1:0]    BRESP;
  logic [AW-1:0] ARADDR;
  logic [2:0]    ARPROT;
  logic          ARVALID;
  logic          ARREADY;
  logic          RREADY;
  logic          RVALID;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID,
    output BREADY, ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP,
    input  ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID,
    input  BREADY, ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BVALID, BRESP,
    output ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS word registers; last one is a
// read-only ID. Write and read channels run independently.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 16,
  parameter logic [31:0] ID_VALUE   = ID_VALUE_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic                    BREADY,
  output logic                    BVALID,
  output logic [1:0]              BRESP,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]              ARPROT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic                    RREADY,
  output logic                    RVALID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LIMIT =
    ADDR_WIDTH'(4 * NUM_REGS);
  localparam logic [IW-1:0] ID_IDX = IW'(REG_ID_IDX);

  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          commit, wr_ok, rd_oor;
  logic [IW-1:0] w_idx, r_idx;
  logic          unused_prot;

  assign unused_prot = ^{AWPROT, ARPROT};

  assign aw_hs  = AWVALID & awready_q;
  assign w_hs   = WVALID & wready_q;
  assign b_hs   = BREADY & bvalid_q;
  assign ar_hs  = ARVALID & arready_q;
  assign r_hs   = RREADY & rvalid_q;
  assign commit = aw_held_q & w_held_q;
  assign w_idx  = awaddr_q[IW+1:2];
  assign r_idx  = ARADDR[IW+1:2];
  assign wr_ok  = (awaddr_q < LIMIT) && (w_idx != ID_IDX);
  assign rd_oor = ARADDR >= LIMIT;

  // Write path: hold AW/W until both present, commit, then respond on B.
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = WDATA;
      wstrb_d  = WSTRB;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (wr_ok) begin
        regs_d[w_idx] = byte_merge(regs_q[w_idx], wdata_q, wstrb_q);
      end
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end
    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
  end

  // Read path: capture register contents on AR, hold R until accepted.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_oor ? RESP_SLVERR : RESP_OKAY;
      unique case (1'b1)
        rd_oor:            rdata_d = '0;
        (r_idx == ID_IDX): rdata_d = ID_VALUE;
        default:           rdata_d = regs_q[r_idx];
      endcase
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
    arready_d = ~rvalid_d;
  end

  // State registers for both channels and the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for axi_lite_slave_regs: directed cases plus
// random traffic against a word-array reference model.
module tb_axi_lite_slave_regs;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  int unsigned model [16];

  axi_lite_if #(.AW(32)) bus ();

  axi_lite_slave_regs dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .AWADDR  (bus.AWADDR),
    .AWPROT  (bus.AWPROT),
    .AWVALID (bus.AWVALID),
    .AWREADY (bus.AWREADY),
    .WDATA   (bus.WDATA),
    .WSTRB   (bus.WSTRB),
    .WVALID  (bus.WVALID),
    .WREADY  (bus.WREADY),
    .BREADY  (bus.BREADY),
    .BVALID  (bus.BVALID),
    .BRESP   (bus.BRESP),
    .ARADDR  (bus.ARADDR),
    .ARPROT  (bus.ARPROT),
    .ARVALID (bus.ARVALID),
    .ARREADY (bus.ARREADY),
    .RREADY  (bus.RREADY),
    .RVALID  (bus.RVALID),
    .RDATA   (bus.RDATA),
    .RRESP   (bus.RRESP)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: bytes per strobe, only regs 0..14 writable.
  task automatic ref_write(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [3:0]  s,
                           output logic [1:0] resp);
    int idx;
    idx = int'(a) / 4;
    if (a >= 32'd64 || idx == 15) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      for (int b = 0; b < 4; b++) begin
        if (s[b]) begin
          model[idx] = (model[idx] & ~(32'hFF << (8 * b)))
                     | (d & (32'hFF << (8 * b)));
        end
      end
    end
  endtask

  task automatic ref_read(input logic [31:0] a,
                          output logic [31:0] d,
                          output logic [1:0]  resp);
    if (a >= 32'd64) begin
      d = 0;
      resp = 2'b10;
    end else if (a / 4 == 15) begin
      d = 32'hDA7A_0001;
      resp = 2'b00;
    end else begin
      d = model[a / 4];
      resp = 2'b00;
    end
  endtask

  task automatic do_write(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0]  s,
                          input int aw_dly,
                          input int w_dly,
                          input int b_dly,
                          output logic [1:0] resp);
    bit ok;
    fork
      begin
        bit aok;
        aok = 0;
        repeat (aw_dly) @(posedge clk);
        #1;
        bus.AWADDR  = a;
        bus.AWVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (bus.AWREADY) begin
            aok = 1;
            break;
          end
        end
        @(posedge clk);
        #1;
        bus.AWVALID = 1'b0;
        if (!aok) chk("aw_timeout", 0, 1);
      end
      begin
        bit wok;
        wok = 0;
        repeat (w_dly) @(posedge clk);
        #1;
        bus.WDATA  = d;
        bus.WSTRB  = s;
        bus.WVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (bus.WREADY) begin
            wok = 1;
            break;
          end
        end
        @(posedge clk);
        #1;
        bus.WVALID = 1'b0;
        if (!wok) chk("w_timeout", 0, 1);
      end
    join
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.BVALID) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("b_timeout", 0, 1);
    resp = bus.BRESP;
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      chk("bvalid_hold", 32'(bus.BVALID), 1);
      chk("bresp_hold", 32'(bus.BRESP), 32'(resp));
    end
    bus.BREADY = 1'b1;
    @(posedge clk);
    #1;
    bus.BREADY = 1'b0;
    chk("bvalid_drop", 32'(bus.BVALID), 0);
  endtask

  task automatic do_read(input logic [31:0] a,
                         input int r_dly,
                         output logic [31:0] d,
                         output logic [1:0]  resp);
    bit ok;
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.ARREADY) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("ar_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.ARVALID = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.RVALID) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("r_timeout", 0, 1);
    d    = bus.RDATA;
    resp = bus.RRESP;
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      chk("rvalid_hold", 32'(bus.RVALID), 1);
      chk("rdata_hold", bus.RDATA, d);
    end
    bus.RREADY = 1'b1;
    @(posedge clk);
    #1;
    bus.RREADY = 1'b0;
    chk("rvalid_drop", 32'(bus.RVALID), 0);
  endtask

  task automatic wr_chk(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0]  s,
                        input int aw_dly,
                        input int w_dly,
                        input int b_dly);
    logic [1:0] got, exp;
    ref_write(a, d, s, exp);
    do_write(a, d, s, aw_dly, w_dly, b_dly, got);
    chk({tag, "_bresp"}, 32'(got), 32'(exp));
  endtask

  task automatic rd_chk(input string tag,
                        input logic [31:0] a,
                        input int r_dly);
    logic [31:0] gd, ed;
    logic [1:0]  gr, er;
    ref_read(a, ed, er);
    do_read(a, r_dly, gd, gr);
    chk({tag, "_rdata"}, gd, ed);
    chk({tag, "_rresp"}, 32'(gr), 32'(er));
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.AWADDR  = '0;
    bus.AWPROT  = '0;
    bus.AWVALID = 1'b0;
    bus.WDATA   = '0;
    bus.WSTRB   = '0;
    bus.WVALID  = 1'b0;
    bus.BREADY  = 1'b0;
    bus.ARADDR  = '0;
    bus.ARPROT  = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_readys", {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 0);
    chk("rst_valids", {30'd0, bus.BVALID, bus.RVALID}, 0);
    chk("rst_rdata", bus.RDATA, 0);
    chk("rst_resps", {28'd0, bus.BRESP, bus.RRESP}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_readys",
        {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'd7);

    rd_chk("rd00", 32'h00, 0);
    wr_chk("wr04_full", 32'h04, 32'hA5A5_1234, 4'hF, 0, 0, 0);
    rd_chk("rd04_full", 32'h04, 0);
    chk("model04", model[1], 32'hA5A5_1234);
    wr_chk("wr04_b1", 32'h04, 32'hFFFF_FFFF, 4'b0010, 0, 0, 0);
    rd_chk("rd04_b1", 32'h04, 0);
    chk("model04_b1", model[1], 32'hA5A5_FF34);
    wr_chk("wr08_wfirst", 32'h08, 32'h1234_5678, 4'hF, 3, 0, 5);
    rd_chk("rd08_wfirst", 32'h08, 2);
    wr_chk("wr0c_awfirst", 32'h0C, 32'hCAFE_F00D, 4'hF, 0, 3, 1);
    rd_chk("rd0c", 32'h0C, 0);
    rd_chk("rd3c", 32'h3C, 0);
    wr_chk("wr3c", 32'h3C, 32'h1111_1111, 4'hF, 0, 0, 0);
    rd_chk("rd3c_after", 32'h3C, 0);
    rd_chk("rd40", 32'h40, 3);
    wr_chk("wr40", 32'h40, 32'h2222_2222, 4'hF, 0, 0, 0);
    wr_chk("wr04_strb0", 32'h04, 32'h0, 4'h0, 0, 0, 0);
    rd_chk("rd05_unaligned", 32'h05, 0);
    for (int i = 0; i < 16; i++) rd_chk("sweep", 32'(4 * i), 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 32'h4F));
      if ($urandom_range(0, 1) == 1) begin
        wr_chk("rnd_wr", a, $urandom, 4'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3));
      end else begin
        rd_chk("rnd_rd", a, $urandom_range(0, 3));
      end
    end
    for (int i = 0; i < 16; i++) rd_chk("sweep2", 32'(4 * i), 0);

    bus.ARADDR  = 32'h04;
    bus.ARVALID = 1'b1;
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    chk("arst_valids", {30'd0, bus.BVALID, bus.RVALID}, 0);
    chk("arst_readys",
        {29'd0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 0);
    chk("arst_rdata", bus.RDATA, 0);
    bus.ARVALID = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_chk("rd04_cleared", 32'h04, 0);
    rd_chk("rd3c_post_rst", 32'h3C, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
